seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Sequences one digit nibble at a time into the existing 2-stage registered binary-to-7-segment decoder (input register, then output register).
- Drives the active-low anode lines so each lit digit lines up with the decoder's registered segment output.
- Accepts new display values via a valid/ready handshake and applies them only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seg_scan_ctrl.sv | 111 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed common-anode 7-segment scan controller with frame-boundary value commit
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN (suppress leading-zero digits).
module seg_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int DEC_LAT      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [4*N_DIGITS-1:0]   load_data,
    output logic                    load_ready,
    output logic [3:0]              dig_out,
    output logic [N_DIGITS-1:0]     an_out,
    output logic                    frame_done
);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t                            state;
    logic [CW-1:0]                     cnt;
    logic [IW-1:0]                     idx;
    logic [4*N_DIGITS-1:0]             active;
    logic [4*N_DIGITS-1:0]             pend_val;
    logic                              pending;
    logic [N_DIGITS-1:0]               an_raw;
    logic [DEC_LAT-1:0][N_DIGITS-1:0]  an_pipe;
    logic [N_DIGITS-1:0]               an_drive;
    logic                              lz_blank;

    always_comb begin
        an_drive      = '1;
        an_drive[idx] = 1'b0;
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [4*N_DIGITS-1:0] upper;
    // Current digit and everything above it are zero; digit 0 is never suppressed.
    assign upper    = active >> {idx, 2'b00};
    assign lz_blank = (idx != '0) && (upper == '0);
`else
    assign lz_blank = 1'b0;
`endif

    assign an_out = an_pipe[DEC_LAT-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            pend_val   <= '0;
            pending    <= 1'b0;
            load_ready <= 1'b1;
            frame_done <= 1'b0;
            dig_out    <= 4'h0;
            an_raw     <= '1;
            an_pipe    <= '1;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state      <= ST_DRIVE;
                        cnt        <= '0;
                        frame_done <= (idx == IDX_LAST) && (DRIVE_LAST == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt == DRIVE_LAST) begin
                        state <= ST_BLANK;
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                    end else begin
                        cnt        <= cnt + CW'(1);
                        // Registered pulse: raise it for the cycle that will be the frame's last.
                        frame_done <= (idx == IDX_LAST) && (cnt + CW'(1) == DRIVE_LAST);
                    end
                end
            endcase

            // pending and load_ready are mutually exclusive, so commit and accept never coincide.
            if (frame_done && pending) begin
                active     <= pend_val;
                pending    <= 1'b0;
                load_ready <= 1'b1;
            end else if (load_valid && load_ready) begin
                pend_val   <= load_data;
                pending    <= 1'b1;
                load_ready <= 1'b0;
            end

            dig_out    <= active[{idx, 2'b00} +: 4];
            an_raw     <= (state == ST_DRIVE && !lz_blank) ? an_drive : '1;
            an_pipe[0] <= an_raw;
            for (int i = 1; i < DEC_LAT; i++) begin
                an_pipe[i] <= an_pipe[i-1];
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl against a frame-arithmetic reference model
module tb_seg_scan_ctrl;
    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int BC    = 2;
    localparam int DL    = 2;
    localparam int SLOT  = BC + RD;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic        load_ready;
    logic [3:0]  dig_out;
    logic [3:0]  an_out;
    logic        frame_done;

    seg_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .DEC_LAT(DL)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .dig_out(dig_out), .an_out(an_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        logic [3:0] an;
        logic [3:0] dig;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    // Reference model: act_hist[k] is the committed value during cycle k since reset.
    logic [15:0] act_hist[$];
    int          k = 0;
    logic        m_pending = 1'b0;
    logic [15:0] m_pend_val = 16'h0;
    logic        m_ready = 1'b1;
    logic        offer = 1'b0;
    logic [15:0] offer_data = 16'h0;
    bit          rand_en = 1'b0;
    bit          started = 1'b0;

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        logic [15:0] s;
        s = v >> (4 * d);
        return s[3:0];
    endfunction

    function automatic logic [3:0] lit_anodes(input int s, input logic [15:0] v);
        int          p;
        int          d;
        logic [3:0]  one;
        p   = s % FRAME;
        d   = p / SLOT;
        one = 4'b0001;
        if ((p % SLOT) < BC) return 4'hF;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (d != 0 && (v >> (4 * d)) == 16'h0) return 4'hF;
`endif
        return ~(one << d);
    endfunction

    function automatic exp_t expected(input int c);
        exp_t e;
        e.cyc = c;
        e.an  = (c < 1 + DL) ? 4'hF : lit_anodes(c - 1 - DL, act_hist[c - 1 - DL]);
        e.dig = (c < 1) ? 4'h0 : nib(act_hist[c - 1], ((c - 1) % FRAME) / SLOT);
        e.fd  = (c % FRAME) == FRAME - 1;
        e.rdy = m_ready;
        return e;
    endfunction

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        v = 16'($urandom);
        for (int d = 0; d < 4; d++)
            if ($urandom_range(0, 2) == 0) v[4*d +: 4] = 4'h0;
        return v;
    endfunction

    task automatic model_reset();
        k = 0;
        act_hist.delete();
        act_hist.push_back(16'h0);
        m_pending = 1'b0;
        m_ready   = 1'b1;
        offer     = 1'b0;
    endtask

    task automatic step();
        bit          fd;
        bit          xfer;
        bit          commit;
        logic [15:0] nxt;
        if (rand_en && !offer && $urandom_range(0, 7) == 0) begin
            offer      = 1'b1;
            offer_data = rand_val();
        end
        exp_q.push_back(expected(k));
        load_valid = offer;
        load_data  = offer ? offer_data : 16'($urandom);
        fd     = (k % FRAME) == FRAME - 1;
        xfer   = offer && m_ready;
        commit = fd && m_pending;
        nxt    = commit ? m_pend_val : act_hist[k];
        if (commit) begin
            m_pending = 1'b0;
            m_ready   = 1'b1;
        end
        if (xfer) begin
            m_pending  = 1'b1;
            m_pend_val = offer_data;
            m_ready    = 1'b0;
            offer      = 1'b0;
        end
        act_hist.push_back(nxt);
        k++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        if (started) exp_q.push_back(expected(k));
        rst_n      = 1'b0;
        load_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_reset();
            if (i < n - 1) exp_q.push_back(expected(0));
        end
        rst_n   = 1'b1;
        started = 1'b1;
    endtask

    task automatic run_until(input int p);
        while ((k % FRAME) != p) step();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (an_out === e.an && dig_out === e.dig && frame_done === e.fd && load_ready === e.rdy) begin
                n_pass++;
            end else begin
                $display("FAIL scan cyc=%0d an_out=%b exp %b dig_out=%h exp %h frame_done=%b exp %b load_ready=%b exp %b",
                         e.cyc, an_out, e.an, dig_out, e.dig, frame_done, e.fd, load_ready, e.rdy);
            end
        end
    end

    initial begin
        do_reset(3);

        // Load 1234 at cycle 1, then hold ABCD while pending.
        step();
        offer = 1'b1; offer_data = 16'h1234;
        step();
        offer = 1'b1; offer_data = 16'hABCD;
        repeat (2 * FRAME + 4) step();

        // Offer on the frame_done cycle with nothing pending.
        run_until(FRAME - 1);
        offer = 1'b1; offer_data = 16'h0050;
        step();
        repeat (2 * FRAME + 2) step();

        run_until(FRAME - 1);
        offer = 1'b1; offer_data = 16'h0000;
        step();
        repeat (2 * FRAME) step();

        // Reset during DRIVE of digit 2 with a value pending.
        run_until(0);
        offer = 1'b1; offer_data = 16'h9876;
        run_until(2 * SLOT + BC + 1);
        do_reset(2);
        repeat (FRAME + 2) step();

        rand_en = 1'b1;
        repeat (30 * FRAME) step();
        rand_en = 1'b0;

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain queue_left=%0d required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
